scalar_alu_arbiter: RTL and testbench
=====================================

SCALAR_ALU_ARBITER -- requirements
Module: scalar_alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 36, scalar datapath width.
REQ-002 Parameter IMM_W, default 25, immediate field width.
REQ-003 Parameter ALU_LAT, default 2, fixed ALU latency in cycles from alu_valid to result (legal range 1..8).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester request valid (bit N = requester N).
REQ-007 req_ready  out  2  per-requester grant; a transfer occurs when req_valid[N] and req_ready[N] are both high.
REQ-008 req_a  in  2*WIDTH  operand A; requester N at [N*WIDTH +: WIDTH].
REQ-009 req_b  in  2*WIDTH  operand B, packed as req_a.
REQ-010 req_imm  in  2*IMM_W  immediate, packed per requester.
REQ-011 req_use_imm  in  2  1 selects the sign-extended immediate instead of operand B.
REQ-012 req_op  in  8  ALU opcode, 4 bits per requester.
REQ-013 stall  in  1  downstream stall; blocks new grants only.
REQ-014 alu_valid  out  1  registered issue strobe to ALU.
REQ-015 alu_a, alu_b  out  WIDTH each  registered ALU operands.
REQ-016 alu_op  out  4  registered ALU opcode.
REQ-017 alu_data  in  WIDTH  ALU result.
REQ-018 alu_flags  in  3  ALU {zero, sign, overflow}.
REQ-019 rsp_valid  out  2  one-hot result strobe to the owning requester.
REQ-020 rsp_data  out  WIDTH  result.
REQ-021 rsp_flags  out  3  {zero, sign, overflow}.
REQ-022 busy  out  1  high while any operation is issued or in flight.

Function
REQ-023 At most one req_ready bit SHALL be high per cycle; req_ready is combinational from req_valid, stall, rst and rr_ptr.
REQ-024 req_ready SHALL be 0 while stall or rst is high.
REQ-025 Only one requester valid: that requester SHALL be granted. Both valid: requester rr_ptr SHALL be granted.
REQ-026 After a grant to N, rr_ptr SHALL become ~N. Without a grant, including during stall, rr_ptr SHALL hold.
REQ-027 On a grant in cycle T, the edge ending T SHALL load alu_a, alu_b and alu_op from requester N and set alu_valid=1 for cycle T+1. alu_b = req_use_imm[N] ? sign-extended req_imm[N] : req_b[N].
REQ-028 A cycle with no grant SHALL produce alu_valid=0 next cycle. alu_a, alu_b and alu_op SHALL hold their last values.
REQ-029 An ALU_LAT-deep tag shift register of {valid, owner} SHALL advance every cycle regardless of stall. An entry enters when alu_valid is high.
REQ-030 When the tag head is valid (cycle T+1+ALU_LAT), rsp_valid SHALL be one-hot for the owner, rsp_data=alu_data and rsp_flags=alu_flags, combinationally.
REQ-031 When the tag head is invalid, rsp_valid, rsp_data and rsp_flags SHALL all be 0.
REQ-032 Back-to-back grants SHALL sustain one operation per cycle. Responses SHALL return in issue order and cannot be backpressured.
REQ-033 busy SHALL equal alu_valid OR any valid tag entry.

Reset
REQ-034 rst high SHALL immediately clear the following: rr_ptr=0, alu_valid=0, alu_a=0, alu_b=0, alu_op=0, all tag entries, rsp_valid=0, busy=0.
REQ-035 Operations in flight when rst asserts SHALL be discarded; rsp_valid SHALL never be produced for them.
REQ-036 The first grant after rst deasserts SHALL be evaluated on the first rising edge with rst low.

Verification
REQ-037 Post-reset, ALU_LAT=2, req0 only, a=5, b=3, op=0, use_imm=0 -> req_ready=01 in cycle 0, alu_valid=1 with a=5, b=3 in cycle 1, rsp_valid=01 in cycle 3 with rsp_data equal to alu_data.
REQ-038 req1 with use_imm=1: imm=25'h1FFFFFF -> alu_b=36'hFFFFFFFFF. imm=25'h0FFFFFF -> alu_b=36'h000FFFFFF.
REQ-039 Both valid for 6 cycles after reset -> grants 0,1,0,1,0,1 and rsp_valid sequence 01,10,01,10,01,10 starting at cycle 1+ALU_LAT.
REQ-040 Both valid, one grant to 0, then stall high for 3 cycles -> req_ready=00 and alu_valid=0 during the stall, in-flight response still delivered; first grant after stall goes to requester 1.
REQ-041 Two ops in flight, rst pulsed 1 cycle -> busy=0 and rsp_valid=00 for all following cycles until a new grant.
REQ-042 req0 valid for 4 consecutive cycles -> 4 consecutive alu_valid cycles and 4 consecutive rsp_valid=01 cycles, with data in issue order.

Source files
------------

// File: rtl/scalar_alu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency scalar ALU.
// Registers one issue per cycle and routes results back by tag order.

module scalar_alu_arbiter_lane #(
    parameter int WIDTH = 36,
    parameter int IMM_W = 25
) (
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    output logic [WIDTH-1:0] opb
);
    assign opb = use_imm ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : b;
endmodule

module scalar_alu_arbiter #(
    parameter int WIDTH   = 36,
    parameter int IMM_W   = 25,
    parameter int ALU_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [2*IMM_W-1:0] req_imm,
    input  logic [1:0]         req_use_imm,
    input  logic [7:0]         req_op,
    input  logic               stall,
    output logic               alu_valid,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_data,
    input  logic [2:0]         alu_flags,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [2:0]         rsp_flags,
    output logic               busy
);
    localparam int NUM_REQ = 2;

    logic [NUM_REQ-1:0][WIDTH-1:0] lane_a, lane_b;
    logic [NUM_REQ-1:0][3:0]       lane_op;

    assign lane_a  = req_a;
    assign lane_op = req_op;

    scalar_alu_arbiter_lane #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_lane [NUM_REQ-1:0] (
        .b       (req_b),
        .imm     (req_imm),
        .use_imm (req_use_imm),
        .opb     (lane_b)
    );

    // Arbitration: a lone requester always wins, contention goes to rr_ptr.
    logic rr_ptr, gnt, gnt_idx;
    assign gnt       = (|req_valid) & ~stall & ~rst;
    assign gnt_idx   = (&req_valid) ? rr_ptr : req_valid[1];
    assign req_ready = gnt ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    logic alu_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            alu_valid <= 1'b0;
            alu_own   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
        end else begin
            alu_valid <= gnt;
            if (gnt) begin
                rr_ptr  <= ~gnt_idx;
                alu_own <= gnt_idx;
                alu_a   <= lane_a[gnt_idx];
                alu_b   <= lane_b[gnt_idx];
                alu_op  <= lane_op[gnt_idx];
            end
        end
    end

    // Tag pipe: stage 0 is the live issue, stage ALU_LAT lines up with alu_data.
    logic [ALU_LAT-1:0] tag_vld, tag_own;
    logic [ALU_LAT:0]   vld_pipe, own_pipe;
    assign vld_pipe = {tag_vld, alu_valid};
    assign own_pipe = {tag_own, alu_own};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld <= vld_pipe[ALU_LAT-1:0];
            tag_own <= own_pipe[ALU_LAT-1:0];
        end
    end

    assign rsp_valid = vld_pipe[ALU_LAT] ? (own_pipe[ALU_LAT] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = vld_pipe[ALU_LAT] ? alu_data  : '0;
    assign rsp_flags = vld_pipe[ALU_LAT] ? alu_flags : '0;
    assign busy      = |vld_pipe;
endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// Directed bench: arbitration order, immediate extension, stall, reset flush
// and ordered result return against a small adder ALU model.

module tb_scalar_alu_arbiter;
    localparam int WIDTH = 36, IMM_W = 25, ALU_LAT = 2;

    logic               clk = 1'b0, rst = 1'b1, stall = 1'b0;
    logic [1:0]         req_valid = '0, req_ready, req_use_imm = '0, rsp_valid;
    logic [2*WIDTH-1:0] req_a = '0, req_b = '0;
    logic [2*IMM_W-1:0] req_imm = '0;
    logic [7:0]         req_op = '0;
    logic               alu_valid, busy;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_data, rsp_data;
    logic [3:0]         alu_op;
    logic [2:0]         alu_flags, rsp_flags;

    int nchk = 0, nerr = 0;

    scalar_alu_arbiter #(.WIDTH(WIDTH), .IMM_W(IMM_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_imm(req_imm), .req_use_imm(req_use_imm),
        .req_op(req_op), .stall(stall), .alu_valid(alu_valid), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .alu_data(alu_data), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: adder with ALU_LAT cycles of latency, flags {zero, sign, 0}
    logic [WIDTH-1:0] apipe [ALU_LAT];
    initial for (int i = 0; i < ALU_LAT; i++) apipe[i] = '0;
    always @(posedge clk) begin
        apipe[0] <= alu_a + alu_b;
        for (int i = 1; i < ALU_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign alu_data  = apipe[ALU_LAT-1];
    assign alu_flags = {alu_data == '0, alu_data[WIDTH-1], 1'b0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; stall = 1'b0; req_use_imm = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_lane(input int n, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [3:0] op);
        req_a[n*WIDTH +: WIDTH] = a;
        req_b[n*WIDTH +: WIDTH] = b;
        req_op[n*4 +: 4] = op;
    endtask

    initial begin
        // reset state, even with both requesting
        req_valid = 2'b11; #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_alu_valid", alu_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp", rsp_valid, 2'b00);
        do_reset();

        // single op from requester 0
        set_lane(0, 36'd5, 36'd3, 4'd0); req_valid = 2'b01; #1;
        chk("r37_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        chk("r37_alu_valid", alu_valid, 1'b1);
        chk("r37_alu_a", alu_a, 36'd5);
        chk("r37_alu_b", alu_b, 36'd3);
        chk("r37_busy", busy, 1'b1);
        tick();
        chk("r37_rsp_early", rsp_valid, 2'b00);
        tick();
        chk("r37_rsp_valid", rsp_valid, 2'b01);
        chk("r37_rsp_data", rsp_data, 36'd8);
        chk("r37_rsp_flags", rsp_flags, 3'b000);
        tick();
        chk("r37_rsp_done", rsp_valid, 2'b00);
        chk("r37_idle", busy, 1'b0);

        // requester 1 with sign-extended immediates
        do_reset();
        set_lane(1, 36'd0, 36'd123, 4'hA);
        req_use_imm = 2'b10; req_imm[IMM_W +: IMM_W] = 25'h1FFFFFF; req_valid = 2'b10; #1;
        chk("r38_ready0", req_ready, 2'b10);
        tick();
        req_imm[IMM_W +: IMM_W] = 25'h0FFFFFF; #1;
        chk("r38_neg_b", alu_b, 36'hFFFFFFFFF);
        chk("r38_op", alu_op, 4'hA);
        chk("r38_ready1", req_ready, 2'b10);
        tick(); req_valid = 2'b00; req_use_imm = 2'b00;
        chk("r38_pos_b", alu_b, 36'h000FFFFFF);
        tick();
        chk("r38_rsp_valid", rsp_valid, 2'b10);
        chk("r38_rsp_data", rsp_data, 36'hFFFFFFFFF);
        chk("r38_rsp_flags", rsp_flags, 3'b010);
        tick();
        chk("r38_rsp_data2", rsp_data, 36'h000FFFFFF);

        // both requesting for 6 cycles: alternate, responses 3 cycles later
        do_reset();
        for (int i = 0; i < 10; i++) begin
            int k;
            k = i - 1 - ALU_LAT;
            req_valid = (i < 6) ? 2'b11 : 2'b00;
            set_lane(0, 36'(16 + i), 36'd0, 4'd1);
            set_lane(1, 36'(32 + i), 36'd0, 4'd2);
            #1;
            if (i < 6) chk($sformatf("r39_gnt%0d", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
            if (k >= 0 && k < 6) begin
                chk($sformatf("r39_rsp%0d", k), rsp_valid, (k % 2) ? 2'b10 : 2'b01);
                chk($sformatf("r39_dat%0d", k), rsp_data, (k % 2) ? 36'(32 + k) : 36'(16 + k));
            end else if (i >= 1 + ALU_LAT) begin
                chk($sformatf("r39_norsp%0d", i), rsp_valid, 2'b00);
            end
            tick();
        end

        // stall after one grant
        do_reset();
        set_lane(0, 36'd7, 36'd1, 4'd0); set_lane(1, 36'd9, 36'd1, 4'd0);
        req_valid = 2'b11; #1;
        chk("r40_gnt0", req_ready, 2'b01);
        tick(); stall = 1'b1; #1;
        chk("r40_stall_ready1", req_ready, 2'b00);
        tick();
        chk("r40_stall_ready2", req_ready, 2'b00);
        chk("r40_stall_alu2", alu_valid, 1'b0);
        tick();
        chk("r40_stall_alu3", alu_valid, 1'b0);
        chk("r40_inflight_rsp", rsp_valid, 2'b01);
        chk("r40_inflight_data", rsp_data, 36'd8);
        tick(); stall = 1'b0; #1;
        chk("r40_post_alu", alu_valid, 1'b0);
        chk("r40_post_gnt", req_ready, 2'b10);
        tick(); req_valid = 2'b00;

        // reset with two ops in flight
        do_reset();
        req_valid = 2'b11; tick(); tick(); req_valid = 2'b00;
        chk("r41_busy_before", busy, 1'b1);
        rst = 1'b1; #1;
        chk("r41_busy_rst", busy, 1'b0);
        chk("r41_rsp_rst", rsp_valid, 2'b00);
        tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("r41_rsp%0d", i), rsp_valid, 2'b00);
            chk($sformatf("r41_busy%0d", i), busy, 1'b0);
            tick();
        end

        // req0 streaming 4 ops back to back
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 4) ? 2'b01 : 2'b00;
            set_lane(0, 36'(100 + i), 36'd1, 4'd3);
            #1;
            if (i >= 1 && i <= 4) chk($sformatf("r42_alu%0d", i), alu_valid, 1'b1);
            if (i >= 1 + ALU_LAT && i < 5 + ALU_LAT) begin
                chk($sformatf("r42_rsp%0d", i), rsp_valid, 2'b01);
                chk($sformatf("r42_dat%0d", i), rsp_data, 36'(101 + i - 1 - ALU_LAT));
            end
            tick();
        end
        #1;
        chk("r42_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
